// File: rtl/prod_bcd_conv_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, operand/digit sizes and derived widths.
package prod_bcd_conv_pkg;

    localparam int DIGITS = 3;
    localparam int IN_W   = 8;
    localparam int ITER   = 8;

    // Digit field sits above the binary field in the working shift register.
    localparam int BCD_W  = 4 * DIGITS;
    localparam int SR_W   = BCD_W + IN_W;
    localparam int CNT_W  = 4;

    // Count value during the final shift step of a conversion.
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/prod_bcd_conv_bcd_digit_adj.sv
// Double-dabble digit correction: any BCD digit of 5 or more gets +3 so
// that the following left shift carries correctly into the next digit.
module bcd_digit_adj (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/prod_bcd_conv.sv
// Sequential binary-to-BCD converter for an 8-bit product.
// One adjust-and-shift step per clock, eight steps per conversion.
// All outputs come straight from registers.
module prod_bcd_conv
    import prod_bcd_conv_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [IN_W-1:0]  bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [BCD_W-1:0] bcd_o
);

    state_t             state_q, state_d;
    logic [SR_W-1:0]    shiftReg_q;
    logic [CNT_W-1:0]   iterCnt_q;
    logic [BCD_W-1:0]   bcd_q;
    logic               done_q;

    logic               loadEn;
    logic               shiftEn;
    logic               lastStep;

    logic [BCD_W-1:0]   adjDigits;
    logic [SR_W-1:0]    adjusted;
    logic [SR_W-1:0]    shifted;

    // Correct every digit field of the working register before it shifts.
    for (genvar d = 0; d < DIGITS; d++) begin : gDigit
        bcd_digit_adj uAdj (
            .digit_i (shiftReg_q[IN_W + 4*d +: 4]),
            .digit_o (adjDigits[4*d +: 4])
        );
    end

    assign adjusted = {adjDigits, shiftReg_q[IN_W-1:0]};
    assign shifted  = adjusted << 1;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave IDLE on a start request, return after the eighth shift.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = SHIFT;
            SHIFT:   if (iterCnt_q == LAST_ITER) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath controls decoded from the current state.
    always_comb begin
        loadEn   = 1'b0;
        shiftEn  = 1'b0;
        lastStep = 1'b0;
        unique case (state_q)
            IDLE:    loadEn = start_i;
            SHIFT: begin
                shiftEn  = 1'b1;
                lastStep = (iterCnt_q == LAST_ITER);
            end
            default: ;
        endcase
    end

    // Working register, iteration count, result and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shiftReg_q <= '0;
            iterCnt_q  <= '0;
            bcd_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= lastStep;
            if (loadEn) begin
                shiftReg_q <= {{BCD_W{1'b0}}, bin_i};
                iterCnt_q  <= '0;
            end else if (shiftEn) begin
                shiftReg_q <= shifted;
                iterCnt_q  <= iterCnt_q + 1'b1;
            end
            if (lastStep) begin
                bcd_q <= shifted[SR_W-1:IN_W];
            end
        end
    end

    assign busy_o = (state_q == SHIFT);
    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: tb/tb_prod_bcd_conv.sv
// Scoreboard testbench for prod_bcd_conv: the driver pushes the expected
// decimal digits of each accepted conversion, the monitor pops on DONE.
module tb_prod_bcd_conv;

    typedef struct {
        logic [11:0] bcd;
        int          startEdge;
    } expEntry_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;

    int          cycleCnt = 0;
    int          testsRun = 0;
    int          testsFailed = 0;
    expEntry_t   expQ[$];
    logic [11:0] lastBcd = '0;
    logic        prevDone = 1'b0;

    prod_bcd_conv dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .bin_i   (bin),
        .busy_o  (busy),
        .done_o  (done),
        .bcd_o   (bcd)
    );

    // Free-running clock and edge counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Decimal digits computed arithmetically from the value.
    function automatic logic [11:0] refBcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycleCnt);
        end
    endtask

    // One conversion; optionally a second START at E3 that must be ignored.
    task automatic applyStimulus(input logic [7:0] value, input bit injectIgnored);
        @(negedge clk);
        start = 1'b1;
        bin   = value;
        expQ.push_back('{refBcd(int'(value)), cycleCnt + 1});
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            checkOutput("busy", int'(busy), (k < 8) ? 1 : 0);
            if (k == 0) begin
                start = 1'b0;
                bin   = 8'($urandom);
            end
            if (injectIgnored && k == 2) begin
                start = 1'b1;
                bin   = 8'd7;
            end
            if (injectIgnored && k == 3) start = 1'b0;
        end
    endtask

    // START held high across two conversions; second accepted at E9.
    task automatic applyBackToBack(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start = 1'b1;
        bin   = a;
        expQ.push_back('{refBcd(int'(a)), cycleCnt + 1});
        repeat (9) @(negedge clk);
        bin = b;
        expQ.push_back('{refBcd(int'(b)), cycleCnt + 1});
        @(negedge clk);
        start = 1'b0;
        bin   = 8'($urandom);
        repeat (9) @(negedge clk);
    endtask

    // Monitor: compare every completion with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpectedDone: got done=1 bcd=%0h, expected no completion", bcd);
                end else begin
                    expEntry_t e;
                    e = expQ.pop_front();
                    checkOutput("bcd", int'(bcd), int'(e.bcd));
                    checkOutput("latency", cycleCnt - e.startEdge, 8);
                    for (int d = 0; d < 3; d++)
                        checkOutput("digitRange", int'(bcd[4*d +: 4] <= 4'd9), 1);
                end
                checkOutput("donePulse", int'(prevDone), 0);
            end else begin
                checkOutput("bcdHold", int'(bcd), int'(lastBcd));
            end
            lastBcd  = bcd;
            prevDone = done;
        end else begin
            lastBcd  = '0;
            prevDone = 1'b0;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int order[256];

        rst_n = 1'b0;
        start = 1'b0;
        bin   = 8'd0;
        repeat (3) @(negedge clk);
        checkOutput("rstBusy", int'(busy), 0);
        checkOutput("rstDone", int'(done), 0);
        checkOutput("rstBcd", int'(bcd), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        applyStimulus(8'd0, 1'b0);
        applyStimulus(8'd255, 1'b0);
        applyStimulus(8'd99, 1'b0);
        applyStimulus(8'd100, 1'b0);
        applyStimulus(8'd42, 1'b1);

        // Abort a conversion of 200 with reset just after E4.
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abortBusy", int'(busy), 0);
        checkOutput("abortDone", int'(done), 0);
        checkOutput("abortBcd", int'(bcd), 0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("startInReset", int'(busy), 0);
        applyStimulus(8'd13, 1'b0);

        applyBackToBack(8'd9, 8'd250);

        // Full sweep in random order with random ignored starts.
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j, tmp;
            j = int'($urandom_range(i, 0));
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < 256; i++)
            applyStimulus(8'(order[i]), 1'($urandom_range(1, 0)));

        for (int i = 0; i < 4; i++)
            applyBackToBack(8'($urandom), 8'($urandom));

        for (int i = 0; i < 40 && expQ.size() > 0; i++) @(negedge clk);
        checkOutput("drain", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/prod_bcd_conv.md
PROD_BCD_CONV -- requirements
Module: prod_bcd_conv

Interface
REQ-001 Parameters SHALL be none; operand width is fixed at 8 bits and output at 3 BCD digits.
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 RST  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 START  input  1  SHALL request conversion of BIN; sampled on rising CLK.
REQ-005 BIN  input  8  SHALL be the unsigned binary value (8-bit multiplier product), sampled with START.
REQ-006 BUSY  output  1  SHALL be high while a conversion is in progress.
REQ-007 DONE  output  1  SHALL pulse high for exactly one cycle when BCD is updated.
REQ-008 BCD  output  12  SHALL hold the result: [11:8] hundreds, [7:4] tens, [3:0] ones.

Function
REQ-009 The block SHALL convert using sequential double-dabble: one shift per cycle, 8 shift cycles per conversion.
REQ-010 The FSM SHALL have states IDLE and SHIFT; encoding is defined in the shared package.
REQ-011 In IDLE with START=1 at edge E0: the block SHALL latch BIN into a 20-bit shift register with the upper 12 bits cleared, clear the iteration count to 0, go to SHIFT, and set BUSY=1.
REQ-012 In SHIFT at each edge E1..E8: every digit field >=5 SHALL be incremented by 3 (mod 16), then the register SHALL be shifted left by one, and the count incremented.
REQ-013 At E8 (count reaching 8): the block SHALL load BCD from the digit field, set DONE=1, clear BUSY, and return to IDLE.
REQ-014 Latency SHALL be exactly 8 cycles from the START sampling edge to the DONE rising edge; throughput one conversion per 9 cycles.
REQ-015 DONE SHALL deassert at E9 unless a new conversion completes at that edge, which is impossible by design.
REQ-016 START SHALL be ignored while BUSY=1; BIN changes during SHIFT SHALL NOT affect the result.
REQ-017 START sampled in the cycle DONE=1 (state IDLE) SHALL be accepted normally.
REQ-018 BCD SHALL hold its last value between completions and SHALL change only at the completion edge.
REQ-019 Every digit of every result SHALL be 0-9; the maximum input 255 SHALL yield 12'h255.

Reset
REQ-020 RST=0 SHALL asynchronously force state=IDLE, BUSY=0, DONE=0, BCD=12'h000, shift register=0, count=0.
REQ-021 Reset asserted mid-conversion SHALL abort it with no DONE pulse; the first START after release SHALL begin a fresh conversion.
REQ-022 START SHALL be ignored while RST=0.

Structure
REQ-023 The shared package SHALL hold the FSM state constants, DIGITS=3, IN_W=8, and ITER=8.
REQ-024 One sub-module, bcd_digit_adj (4-bit combinational: out = in>=5 ? in+3 : in), SHALL be instantiated three times.
REQ-025 The block SHALL contain no combinational path from START or BIN to any output.

Verification
REQ-026 BIN=8'd0, START for one cycle -> DONE at E8, BCD=12'h000, BUSY high for E0..E8.
REQ-027 BIN=8'd255 -> BCD=12'h255; BIN=8'd99 -> 12'h099; BIN=8'd100 -> 12'h100.
REQ-028 BIN=8'd42 started, then START with BIN=8'd7 at E3 -> second START ignored, result 12'h042, exactly one DONE.
REQ-029 BIN=8'd200 started, RST low at E4 -> outputs zero immediately, no DONE; after release, start BIN=8'd13 -> 12'h013.
REQ-030 Back-to-back: START held high continuously with BIN=8'd9 then 8'd250 -> DONE pulses 9 cycles apart, results 12'h009 then 12'h250.
REQ-031 Exhaustive sweep 0..255 against a reference model -> all results match and all digits are <=9.
